// File: rtl/bridge_pkg.sv
// ---------------------------------------------------------------------------
// bridge_pkg
// Shared definitions for the AHB-to-APB bridge front-end:
//   - HTRANS encodings
//   - AHB slave state encoding
//   - default bus widths and the queued-request width (write + addr + data)
// ---------------------------------------------------------------------------
package bridge_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int REQ_W      = BUS_ADDR_W + 1 + BUS_DATA_W;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_DATA = 3'd1;
  localparam logic [2:0] ST_RD_PUSH = 3'd2;
  localparam logic [2:0] ST_RD_WAIT = 3'd3;
  localparam logic [2:0] ST_RD_DONE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_WR_DATA = ST_WR_DATA,
    S_RD_PUSH = ST_RD_PUSH,
    S_RD_WAIT = ST_RD_WAIT,
    S_RD_DONE = ST_RD_DONE
  } ahb_state_e;

  // Width of one queued request {write, address, data}.
  function automatic int req_width(input int aw, input int dw);
    return aw + 1 + dw;
  endfunction

endpackage

// File: rtl/bridge_fifo.sv
// ---------------------------------------------------------------------------
// bridge_fifo
// Synchronous FIFO, power-of-2 depth, asynchronous active-high reset.
// Storage is cleared on reset so dout reads as zero while empty after reset.
// A push into a full FIFO is accepted when a pop happens in the same cycle;
// a pop on an empty FIFO is ignored.
// Ports:
//   clk, rst      clock / async active-high reset
//   push, din     write request and data
//   pop           remove head entry
//   dout          head entry (driven from registered storage)
//   full, empty   occupancy flags
//   count         number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
module bridge_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic do_pop;
  logic do_push;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

  // Pointers are PTR_W bits wide, so increments wrap modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ahb_slave_if.sv
// ---------------------------------------------------------------------------
// ahb_slave_if
// AHB-Lite slave front-end for the AHB-to-APB bridge. Each accepted transfer
// is queued as {write, address, data}; the queue head is presented to the
// APB master and popped on its completion strobe Pint. Writes are posted,
// reads hold the AHB bus until their APB read data returns.
// Ports:
//   Hclk, Hreset          clock / async active-high reset
//   Hsel, Haddr, Htrans,  AHB address phase
//   Hwrite, Hready_in
//   Hwdata                AHB write data (data phase)
//   Hreadyout, Hresp,     AHB slave response (Hresp always OKAY)
//   Hrdata
//   addr_temp, data_temp  queue head: {write, address} and write data
//   transfer              queue not empty
//   Pint, rdata_temp      APB completion strobe and read data
// ---------------------------------------------------------------------------
module ahb_slave_if
  import bridge_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = BUS_ADDR_W,
  parameter int DATA_W     = BUS_DATA_W
) (
  input  logic              Hclk,
  input  logic              Hreset,
  input  logic              Hsel,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [1:0]        Htrans,
  input  logic              Hwrite,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic              Hready_in,
  output logic              Hreadyout,
  output logic              Hresp,
  output logic [DATA_W-1:0] Hrdata,
  output logic [ADDR_W:0]   addr_temp,
  output logic [DATA_W-1:0] data_temp,
  output logic              transfer,
  input  logic              Pint,
  input  logic [DATA_W-1:0] rdata_temp
);

  localparam int RW = req_width(ADDR_W, DATA_W);

  ahb_state_e        state_q;
  ahb_state_e        state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] hrdata_q;
  logic [DATA_W-1:0] hrdata_d;

  logic                    fifo_push;
  logic [RW-1:0]           fifo_din;
  logic [RW-1:0]           fifo_dout;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_unused;

  logic accept;
  logic addr_phase_ok;
  logic take;
  logic head_pop;
  logic ready_d;

  // NONSEQ and SEQ both start a real transfer; IDLE/BUSY are ignored.
  assign accept   = Hsel & Hready_in &
                    ((Htrans == HTRANS_NONSEQ) | (Htrans == HTRANS_SEQ));
  assign take     = accept & addr_phase_ok;
  assign head_pop = Pint & ~fifo_empty;

  always_comb begin
    fifo_push     = 1'b0;
    fifo_din      = '0;
    ready_d       = 1'b1;
    addr_phase_ok = 1'b0;
    state_d       = state_q;
    hrdata_d      = hrdata_q;
    case (state_q)
      S_IDLE, S_RD_DONE: begin
        addr_phase_ok = 1'b1;
        if (take) begin
          state_d = Hwrite ? S_WR_DATA : S_RD_PUSH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR_DATA: begin
        // A pop in this cycle frees a slot, so a full queue can still take
        // the write without a wait state.
        if (!fifo_full || head_pop) begin
          fifo_push     = 1'b1;
          fifo_din      = {1'b1, addr_q, Hwdata};
          addr_phase_ok = 1'b1;
          if (take) begin
            state_d = Hwrite ? S_WR_DATA : S_RD_PUSH;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          ready_d = 1'b0;
        end
      end
      S_RD_PUSH: begin
        ready_d = 1'b0;
        if (!fifo_full || head_pop) begin
          fifo_push = 1'b1;
          fifo_din  = {1'b0, addr_q, {DATA_W{1'b0}}};
          state_d   = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        ready_d = 1'b0;
        // Only one read is ever queued, so a read entry at the head is ours;
        // pops of earlier posted writes leave the read waiting.
        if (head_pop && !fifo_dout[RW-1]) begin
          hrdata_d = rdata_temp;
          state_d  = S_RD_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      hrdata_q <= hrdata_d;
      if (take) begin
        addr_q <= Haddr;
      end
    end
  end

  bridge_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (Hclk),
    .rst   (Hreset),
    .push  (fifo_push),
    .pop   (Pint),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count_unused)
  );

  assign Hreadyout = ready_d;
  assign Hresp     = 1'b0;
  assign Hrdata    = hrdata_q;
  assign addr_temp = fifo_dout[RW-1:DATA_W];
  assign data_temp = fifo_dout[DATA_W-1:0];
  assign transfer  = ~fifo_empty;

endmodule

// File: tb/tb_ahb_slave_if.sv
module tb_ahb_slave_if;
  import bridge_pkg::*;

  logic        Hclk = 1'b0;
  logic        Hreset;
  logic        Hsel;
  logic [31:0] Haddr;
  logic [1:0]  Htrans;
  logic        Hwrite;
  logic [31:0] Hwdata;
  logic        Hready_in;
  logic        Hreadyout;
  logic        Hresp;
  logic [31:0] Hrdata;
  logic [32:0] addr_temp;
  logic [31:0] data_temp;
  logic        transfer;
  logic        Pint;
  logic [31:0] rdata_temp;

  int checks = 0;
  int errors = 0;

  // Scoreboard queues: expected APB head at each pop, expected read data.
  logic [64:0] apb_q[$];
  logic [31:0] rd_q[$];
  bit          rd_pending = 1'b0;

  always #5 Hclk = ~Hclk;

  // Single slave on the bus: bus-level HREADY is our own Hreadyout.
  assign Hready_in = Hreadyout;

  ahb_slave_if #(.FIFO_DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .Hclk       (Hclk),
    .Hreset     (Hreset),
    .Hsel       (Hsel),
    .Haddr      (Haddr),
    .Htrans     (Htrans),
    .Hwrite     (Hwrite),
    .Hwdata     (Hwdata),
    .Hready_in  (Hready_in),
    .Hreadyout  (Hreadyout),
    .Hresp      (Hresp),
    .Hrdata     (Hrdata),
    .addr_temp  (addr_temp),
    .data_temp  (data_temp),
    .transfer   (transfer),
    .Pint       (Pint),
    .rdata_temp (rdata_temp)
  );

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: compares the APB head at every pop and Hrdata at every read
  // data-phase completion against the scoreboard queues.
  always @(negedge Hclk) begin
    if (Hreset) begin
      rd_pending = 1'b0;
    end else begin
      if (Pint && transfer) begin
        if (apb_q.size() == 0) begin
          chk("apb_pop_unexpected", {addr_temp, data_temp}, 65'h0);
          if ({addr_temp, data_temp} == 65'h0) begin
            errors++;
            $display("FAIL apb_pop_unexpected: got pop expected none");
          end
        end else begin
          chk("apb_pop_head", {addr_temp, data_temp}, apb_q.pop_front());
        end
      end
      if (rd_pending && Hreadyout) begin
        rd_pending = 1'b0;
        if (rd_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL read_done_unexpected: got Hrdata %0h expected none", Hrdata);
        end else begin
          chk("read_data", {33'h0, Hrdata}, {33'h0, rd_q.pop_front()});
        end
      end
      if (Hsel && Hready_in && Htrans[1] && !Hwrite) rd_pending = 1'b1;
    end
  end

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  task automatic sample();
    @(negedge Hclk);
  endtask

  task automatic addr_phase(input logic wr, input logic [31:0] a);
    Hsel = 1'b1; Htrans = HTRANS_NONSEQ; Hwrite = wr; Haddr = a;
  endtask

  task automatic bus_idle();
    Hsel = 1'b0; Htrans = HTRANS_IDLE; Hwrite = 1'b0; Haddr = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Hreset = 1'b1; Pint = 1'b0; rdata_temp = 32'h0; Hwdata = 32'h0;
    bus_idle();
    sample();
    chk("rst_hreadyout", {64'h0, Hreadyout}, 65'h1);
    chk("rst_transfer",  {64'h0, transfer},  65'h0);
    chk("rst_hrdata",    {33'h0, Hrdata},    65'h0);
    chk("rst_head",      {addr_temp, data_temp}, 65'h0);
    tick();
    Hreset = 1'b0;
    tick();

    // ---- single posted write ----
    addr_phase(1'b1, 32'h1000_0040);
    apb_q.push_back({1'b1, 32'h1000_0040, 32'hDEAD_BEEF});
    sample(); chk("wr1_addr_ready", {64'h0, Hreadyout}, 65'h1);
    tick();
    bus_idle(); Hwdata = 32'hDEAD_BEEF;
    sample(); chk("wr1_data_ready", {64'h0, Hreadyout}, 65'h1);
    tick();
    sample();
    chk("wr1_transfer",  {64'h0, transfer}, 65'h1);
    chk("wr1_addr_temp", {32'h0, addr_temp}, {32'h0, 33'h1_1000_0040});
    chk("wr1_data_temp", {33'h0, data_temp}, {33'h0, 32'hDEAD_BEEF});
    tick();
    Pint = 1'b1;
    tick();
    Pint = 1'b0;
    sample(); chk("wr1_popped", {64'h0, transfer}, 65'h0);
    tick();

    // ---- Pint on empty FIFO is ignored ----
    Pint = 1'b1; tick(); Pint = 1'b0;
    sample();
    chk("empty_pop_count", {61'h0, dut.u_fifo.count}, 65'h0);
    tick();

    // ---- five back-to-back writes, depth 4 ----
    for (int i = 0; i < 6; i++) begin
      if (i < 5) begin
        addr_phase(1'b1, 32'h100 + 32'(i * 4));
        apb_q.push_back({1'b1, 32'h100 + 32'(i * 4), 32'h1111_0000 + 32'(i)});
      end else begin
        bus_idle();
      end
      if (i > 0) Hwdata = 32'h1111_0000 + 32'(i - 1);
      sample();
      chk($sformatf("b2b_ready_%0d", i), {64'h0, Hreadyout}, (i < 5) ? 65'h1 : 65'h0);
      tick();
    end
    sample();
    chk("b2b_stall_hold", {64'h0, Hreadyout}, 65'h0);
    chk("b2b_full_count", {61'h0, dut.u_fifo.count}, 65'h4);
    tick();
    Pint = 1'b1;
    sample(); chk("b2b_pop_release", {64'h0, Hreadyout}, 65'h1);
    tick();
    Pint = 1'b0;
    sample();
    chk("b2b_count_after", {61'h0, dut.u_fifo.count}, 65'h4);
    chk("b2b_head_addr", {32'h0, addr_temp}, {32'h0, 1'b1, 32'h104});
    tick();
    Pint = 1'b1;
    repeat (4) tick();
    Pint = 1'b0;
    sample(); chk("b2b_drained", {64'h0, transfer}, 65'h0);
    tick();

    // ---- single read ----
    addr_phase(1'b0, 32'h2000_0000);
    apb_q.push_back({1'b0, 32'h2000_0000, 32'h0});
    rd_q.push_back(32'h1234_5678);
    tick();
    bus_idle();
    sample(); chk("rd_push_wait", {64'h0, Hreadyout}, 65'h0);
    tick();
    sample();
    chk("rd_wait_ready", {64'h0, Hreadyout}, 65'h0);
    chk("rd_addr_temp",  {32'h0, addr_temp}, {32'h0, 33'h0_2000_0000});
    tick();
    Pint = 1'b1; rdata_temp = 32'h1234_5678;
    tick();
    Pint = 1'b0; rdata_temp = 32'h0;
    sample();
    chk("rd_done_ready",  {64'h0, Hreadyout}, 65'h1);
    chk("rd_done_hrdata", {33'h0, Hrdata}, {33'h0, 32'h1234_5678});
    tick();

    // ---- read ordered behind a posted write ----
    addr_phase(1'b1, 32'h10);
    apb_q.push_back({1'b1, 32'h10, 32'hA5A5_A5A5});
    tick();
    Hwdata = 32'hA5A5_A5A5;
    addr_phase(1'b0, 32'h14);
    apb_q.push_back({1'b0, 32'h14, 32'h0});
    rd_q.push_back(32'hCAFE_F00D);
    tick();
    bus_idle();
    tick();                          // RD_PUSH
    Pint = 1'b1; rdata_temp = 32'hBAD0_BAD0;   // pops the write
    tick();
    Pint = 1'b0; rdata_temp = 32'h0;
    sample();
    chk("ord_still_wait", {64'h0, Hreadyout}, 65'h0);
    chk("ord_head_read",  {32'h0, addr_temp}, {32'h0, 33'h0_0000_0014});
    tick();
    Pint = 1'b1; rdata_temp = 32'hCAFE_F00D;
    tick();
    Pint = 1'b0; rdata_temp = 32'h0;
    sample();
    chk("ord_done_hrdata", {33'h0, Hrdata}, {33'h0, 32'hCAFE_F00D});
    tick();

    // ---- ignored address phases ----
    for (int k = 0; k < 3; k++) begin
      Hsel   = (k != 0);
      Htrans = (k == 0) ? HTRANS_NONSEQ : ((k == 1) ? HTRANS_BUSY : HTRANS_IDLE);
      Hwrite = 1'b1; Haddr = 32'h300;
      tick();
      bus_idle(); Hwdata = 32'h7777_7777;
      sample();
      chk($sformatf("ign_ready_%0d", k), {64'h0, Hreadyout}, 65'h1);
      tick();
      sample();
      chk($sformatf("ign_transfer_%0d", k), {64'h0, transfer}, 65'h0);
      tick();
    end

    // ---- reset during RD_WAIT with two entries queued ----
    addr_phase(1'b1, 32'h30);
    apb_q.push_back({1'b1, 32'h30, 32'h3333_3333});
    tick();
    Hwdata = 32'h3333_3333;
    addr_phase(1'b0, 32'h38);
    apb_q.push_back({1'b0, 32'h38, 32'h0});
    rd_q.push_back(32'h0);
    tick();
    bus_idle();
    tick();                          // RD_PUSH
    sample(); chk("rst_pre_count", {61'h0, dut.u_fifo.count}, 65'h2);
    tick();                          // RD_WAIT
    Hreset = 1'b1;
    apb_q.delete();
    rd_q.delete();
    sample();
    chk("midrst_hreadyout", {64'h0, Hreadyout}, 65'h1);
    chk("midrst_transfer",  {64'h0, transfer},  65'h0);
    chk("midrst_hrdata",    {33'h0, Hrdata},    65'h0);
    tick();
    Hreset = 1'b0;
    tick();
    addr_phase(1'b1, 32'h40);
    apb_q.push_back({1'b1, 32'h40, 32'h5555_AAAA});
    tick();
    bus_idle(); Hwdata = 32'h5555_AAAA;
    sample(); chk("post_rst_wr_ready", {64'h0, Hreadyout}, 65'h1);
    tick();
    sample(); chk("post_rst_transfer", {64'h0, transfer}, 65'h1);
    tick();
    Pint = 1'b1;
    tick();
    Pint = 1'b0;
    repeat (2) tick();

    sample();
    chk("sb_apb_empty", 65'(apb_q.size()), 65'h0);
    chk("sb_rd_empty",  65'(rd_q.size()),  65'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
